// File: rtl/mem_stage_pkg.sv
// ============================================================================
// mem_stage_pkg
// Opcode/funct3 constants shared with the execute stage, FSM state encoding
// for the memory-access stage, and a write-back qualification helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_stage_pkg;

   // Base-ISA major opcodes
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // Load/store width encodings
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Memory stage FSM states
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   // Non-memory instructions that produce a register result
   function automatic logic writes_rd(input logic [6:0] op);
      case (op)
         OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: writes_rd = 1'b1;
         default:                                                   writes_rd = 1'b0;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_align.sv
// ============================================================================
// mem_align
// Combinational byte-lane steering for stores, extraction plus sign/zero
// extension for loads, and misalignment detection.
// Unknown funct3 values are treated as full-word accesses.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_align
   import mem_stage_pkg::*;
(
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rs2_data,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic        misaligned
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed byte and halfword out of the returned word
   always_comb begin
      byte_sel = rdata[7:0];
      case (addr_lo)
         2'd0: byte_sel = rdata[7:0];
         2'd1: byte_sel = rdata[15:8];
         2'd2: byte_sel = rdata[23:16];
         2'd3: byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   // Store steering, load extension and alignment check
   always_comb begin
      be         = 4'b1111;
      wdata      = rs2_data;
      load_data  = rdata;
      misaligned = 1'b0;
      if (is_store) begin
         case (funct3)
            F3_B: begin
               wdata = {4{rs2_data[7:0]}};
               be    = 4'b0001 << addr_lo;
            end
            F3_H: begin
               wdata      = {2{rs2_data[15:0]}};
               be         = addr_lo[1] ? 4'b1100 : 4'b0011;
               misaligned = addr_lo[0];
            end
            default: misaligned = |addr_lo;
         endcase
      end else begin
         case (funct3)
            F3_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU: load_data = {24'd0, byte_sel};
            F3_H: begin
               load_data  = {{16{half_sel[15]}}, half_sel};
               misaligned = addr_lo[0];
            end
            F3_HU: begin
               load_data  = {16'd0, half_sel};
               misaligned = addr_lo[0];
            end
            default: misaligned = |addr_lo;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage
// Memory-access stage: passes non-memory instructions through in one cycle,
// performs loads/stores over a req/ack port, and emits one registered
// write-back record per instruction.
// Optional macro MISALIGN_TRAP_EN: trap misaligned accesses instead of
// silently ignoring the low address bits.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage
   import mem_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] alu_out,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [4:0]  rd,
   input  logic [31:0] rs2_data,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        wb_valid,
   output logic        wb_we,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        err
);

   state_t      state;
   logic [2:0]  funct3_q;
   logic [1:0]  addr_lo_q;
   logic [4:0]  rd_q;
   logic        err_q;

   logic        is_load;
   logic        is_store;
   logic        is_mem;
   logic        trap;

   logic        align_store;
   logic [2:0]  align_f3;
   logic [1:0]  align_a;
   logic [3:0]  align_be;
   logic [31:0] align_wdata;
   logic [31:0] load_data;
   logic        misaligned;

   assign is_load  = (opcode == OPC_LOAD);
   assign is_store = (opcode == OPC_STORE);
   assign is_mem   = is_load | is_store;
   assign in_ready = (state == ST_IDLE);

   // In IDLE the aligner steers the incoming store; in WAIT it extracts the
   // returning load using the fields captured at issue.
   assign align_store = (state == ST_IDLE) ? is_store     : dmem_we;
   assign align_f3    = (state == ST_IDLE) ? funct3       : funct3_q;
   assign align_a     = (state == ST_IDLE) ? alu_out[1:0] : addr_lo_q;

   mem_align u_align (
      .is_store   (align_store),
      .funct3     (align_f3),
      .addr_lo    (align_a),
      .rs2_data   (rs2_data),
      .rdata      (dmem_rdata),
      .be         (align_be),
      .wdata      (align_wdata),
      .load_data  (load_data),
      .misaligned (misaligned)
   );

`ifdef MISALIGN_TRAP_EN
   assign trap = misaligned;
`else
   logic unused_misaligned;
   assign unused_misaligned = misaligned;
   assign trap = 1'b0;
`endif

   assign err = err_q;

   // Stage FSM: accept in IDLE, hold the memory request in WAIT until ack
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         funct3_q   <= 3'd0;
         addr_lo_q  <= 2'd0;
         rd_q       <= 5'd0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= 32'd0;
         dmem_be    <= 4'd0;
         dmem_wdata <= 32'd0;
         wb_valid   <= 1'b0;
         wb_we      <= 1'b0;
         wb_rd      <= 5'd0;
         wb_data    <= 32'd0;
         err_q      <= 1'b0;
      end else begin
         wb_valid <= 1'b0;
         err_q    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  if (!is_mem) begin
                     wb_valid <= 1'b1;
                     wb_we    <= writes_rd(opcode) && (rd != 5'd0);
                     wb_rd    <= rd;
                     wb_data  <= alu_out;
                  end else if (trap) begin
                     wb_valid <= 1'b1;
                     wb_we    <= 1'b0;
                     wb_rd    <= rd;
                     wb_data  <= alu_out;
                     err_q    <= 1'b1;
                  end else begin
                     dmem_req   <= 1'b1;
                     dmem_we    <= is_store;
                     dmem_addr  <= {alu_out[31:2], 2'b00};
                     dmem_be    <= align_be;
                     dmem_wdata <= align_wdata;
                     funct3_q   <= funct3;
                     addr_lo_q  <= alu_out[1:0];
                     rd_q       <= rd;
                     state      <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  wb_valid <= 1'b1;
                  wb_rd    <= rd_q;
                  wb_we    <= !dmem_we && (rd_q != 5'd0);
                  if (!dmem_we)
                     wb_data <= load_data;
                  state    <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
